// File: rtl/usb2_ulpi_pkg.sv
// Shared constants and state encoding for the ULPI register-access engine.
package usb2_ulpi_pkg;

  localparam logic [1:0] TXCMD_REGWR   = 2'b10;
  localparam logic [1:0] TXCMD_REGRD   = 2'b11;
  localparam logic [5:0] EXT_ADDR      = 6'h2F;
  localparam logic [7:0] REG_FUNC_CTRL = 8'h04;
  localparam logic [7:0] REG_OTG_CTRL  = 8'h0A;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_EXT,
    ST_WDATA,
    ST_STP,
    ST_TURN,
    ST_RDATA,
    ST_ABORT,
    ST_DONE
  } reg_state_e;

  // Addresses above the 6-bit immediate range go through the extended TX_CMD.
  function automatic logic is_ext_addr(input logic [7:0] addr);
    return addr > 8'h3F;
  endfunction

endpackage

// File: rtl/usb2_ulpi_rr_arb.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer moves to winner+1 when the grant is accepted.
module usb2_ulpi_rr_arb #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               phy_clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] hit;
  logic               found;

  // hit[gi] is the request sitting gi places after the pointer.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [IDX_W:0] sum;
    assign sum         = {1'b0, ptr_reg} + (IDX_W+1)'(gi);
    assign rot_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                         IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
    assign hit[gi]     = req[rot_idx[gi]];
  end

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && hit[k]) begin
        found     = 1'b1;
        grant_idx = rot_idx[k];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant[gi] = found && (grant_idx == IDX_W'(gi));
  end

  assign ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  always_ff @(posedge phy_clk) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (accept && found) begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/usb2_ulpi_regctl.sv
// ULPI register-access engine: round-robin requesters, immediate/extended
// reads and writes, abort and NXT timeout handling. ULPI_REG_RETRY_EN enables abort retries.
module usb2_ulpi_regctl
  import usb2_ulpi_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 64,
  parameter int RETRY_MAX   = 3
) (
  input  logic                 phy_clk,
  input  logic                 reset,
  input  logic                 bus_free,
  output logic                 bus_busy,
  input  logic [7:0]           phy_d_in,
  output logic [7:0]           phy_d_out,
  output logic                 phy_d_oe,
  input  logic                 phy_dir,
  input  logic                 phy_nxt,
  output logic                 phy_stp,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic [7:0]           rx_cmd,
  output logic                 rx_cmd_valid
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  reg_state_e         state_reg, state_next;
  logic [TMR_W-1:0]   timer_reg;
  logic               timed_out;
  logic               arb_accept;
  logic [NUM_REQ-1:0] arb_grant, gnt_reg;
  logic [IDX_W-1:0]   arb_idx;
  logic               write_reg;
  logic [7:0]         addr_reg, wdata_reg, rdata_reg;
  logic               ext_addr;
  logic               err_reg, err_next;
  logic               d_oe_reg, dir_q_reg, rx_pend_reg, rx_valid_reg;
  logic [7:0]         rx_cmd_reg;
  logic               retry_ok;

  assign arb_accept = (state_reg == ST_IDLE) && bus_free && (|req_valid) && !phy_dir;
  assign ext_addr   = is_ext_addr(addr_reg);
  assign timed_out  = (timer_reg == TMR_W'(TIMEOUT_CYC - 1));

  usb2_ulpi_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .phy_clk   (phy_clk),
    .reset     (reset),
    .req       (req_valid),
    .accept    (arb_accept),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

`ifdef ULPI_REG_RETRY_EN
  localparam int RTY_W = $clog2(RETRY_MAX + 2);
  logic [RTY_W-1:0] retry_reg;
  assign retry_ok = (retry_reg < RTY_W'(RETRY_MAX));

  always_ff @(posedge phy_clk) begin
    if (reset || arb_accept) begin
      retry_reg <= '0;
    end else if (state_reg == ST_ABORT && state_next == ST_CMD) begin
      retry_reg <= retry_reg + RTY_W'(1);
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (arb_accept) begin
          state_next = ST_CMD;
          err_next   = 1'b0;
        end
      end
      ST_CMD: begin
        if (phy_dir)        state_next = ST_ABORT;
        else if (phy_nxt)   state_next = ext_addr ? ST_EXT : (write_reg ? ST_WDATA : ST_TURN);
        else if (timed_out) begin state_next = ST_DONE; err_next = 1'b1; end
      end
      ST_EXT: begin
        if (phy_dir)        state_next = ST_ABORT;
        else if (phy_nxt)   state_next = write_reg ? ST_WDATA : ST_TURN;
        else if (timed_out) begin state_next = ST_DONE; err_next = 1'b1; end
      end
      ST_WDATA: begin
        if (phy_dir)        state_next = ST_ABORT;
        else if (phy_nxt)   state_next = ST_STP;
        else if (timed_out) begin state_next = ST_DONE; err_next = 1'b1; end
      end
      ST_STP:   state_next = ST_DONE;
      // DIR together with NXT means the PHY started a receive packet instead.
      ST_TURN: begin
        if (phy_dir)        state_next = phy_nxt ? ST_ABORT : ST_RDATA;
        else if (timed_out) begin state_next = ST_DONE; err_next = 1'b1; end
      end
      ST_RDATA: state_next = ST_DONE;
      ST_ABORT: begin
        if (!phy_dir) begin
          if (retry_ok) state_next = ST_CMD;
          else begin state_next = ST_DONE; err_next = 1'b1; end
        end else if (timed_out) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge phy_clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      err_reg   <= 1'b0;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      if (state_next != state_reg)  timer_reg <= '0;
      else if (state_reg != ST_IDLE) timer_reg <= timer_reg + TMR_W'(1);
    end
  end

  always_ff @(posedge phy_clk) begin
    if (reset) begin
      gnt_reg   <= '0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      if (arb_accept) begin
        gnt_reg   <= arb_grant;
        write_reg <= req_write[arb_idx];
        addr_reg  <= req_addr[{arb_idx, 3'b000} +: 8];
        wdata_reg <= req_wdata[{arb_idx, 3'b000} +: 8];
      end
      if (state_reg == ST_RDATA) rdata_reg <= phy_d_in;
    end
  end

  // RX_CMD byte follows the turnaround cycle of a DIR rise seen while idle.
  always_ff @(posedge phy_clk) begin
    if (reset) begin
      d_oe_reg     <= 1'b0;
      dir_q_reg    <= 1'b0;
      rx_pend_reg  <= 1'b0;
      rx_valid_reg <= 1'b0;
      rx_cmd_reg   <= '0;
    end else begin
      d_oe_reg     <= !phy_dir;
      dir_q_reg    <= phy_dir;
      rx_pend_reg  <= (state_reg == ST_IDLE) && phy_dir && !dir_q_reg && !phy_nxt;
      rx_valid_reg <= rx_pend_reg;
      if (rx_pend_reg) rx_cmd_reg <= phy_d_in;
    end
  end

  always_comb begin
    phy_d_out = 8'h00;
    case (state_reg)
      ST_CMD:   phy_d_out = {write_reg ? TXCMD_REGWR : TXCMD_REGRD,
                             ext_addr ? EXT_ADDR : addr_reg[5:0]};
      ST_EXT:   phy_d_out = addr_reg;
      ST_WDATA: phy_d_out = wdata_reg;
      default:  phy_d_out = 8'h00;
    endcase
  end

  assign bus_busy     = (state_reg != ST_IDLE);
  assign phy_stp      = (state_reg == ST_STP);
  assign phy_d_oe     = d_oe_reg;
  assign req_ack      = (state_reg == ST_DONE) ? gnt_reg : '0;
  assign rsp_err      = (state_reg == ST_DONE) && err_reg;
  assign rsp_rdata    = rdata_reg;
  assign rx_cmd       = rx_cmd_reg;
  assign rx_cmd_valid = rx_valid_reg;

endmodule

// File: tb/tb_usb2_ulpi_regctl.sv
// Self-checking bench for usb2_ulpi_regctl: a randomised PHY responder plus a
// round-robin / TX_CMD reference model. Honours ULPI_REG_RETRY_EN.
module tb_usb2_ulpi_regctl;

  localparam int NR = 3;

  logic          phy_clk = 1'b0;
  logic          reset, bus_free, bus_busy;
  logic [7:0]    phy_d_in, phy_d_out;
  logic          phy_d_oe, phy_dir, phy_nxt, phy_stp;
  logic [NR-1:0] req_valid, req_write, req_ack;
  logic [8*NR-1:0] req_addr, req_wdata;
  logic [7:0]    rsp_rdata, rx_cmd;
  logic          rsp_err, rx_cmd_valid;

  usb2_ulpi_regctl #(.NUM_REQ(NR), .TIMEOUT_CYC(64), .RETRY_MAX(3)) dut (
    .phy_clk(phy_clk), .reset(reset), .bus_free(bus_free), .bus_busy(bus_busy),
    .phy_d_in(phy_d_in), .phy_d_out(phy_d_out), .phy_d_oe(phy_d_oe),
    .phy_dir(phy_dir), .phy_nxt(phy_nxt), .phy_stp(phy_stp),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ack(req_ack), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rx_cmd(rx_cmd), .rx_cmd_valid(rx_cmd_valid)
  );

  always #5 phy_clk = ~phy_clk;

  int checks = 0, errors = 0;
  int rr_ptr = 0;
  bit         t_wr   [NR];
  logic [7:0] t_addr [NR];
  logic [7:0] t_wd   [NR];
  logic [7:0] exp_q[$], got_q[$];
  logic [NR-1:0] got_ack;
  logic       got_err;
  logic [7:0] got_rdata;
  int         got_stp, got_stp_bad, got_busy;
  bit         got_done;

  // Reference arbitration: first valid channel at or after the pointer.
  function automatic int pick(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  function automatic bit bytes_match();
    if (got_q.size() != exp_q.size()) return 1'b0;
    for (int k = 0; k < exp_q.size(); k++) if (got_q[k] !== exp_q[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_req(input int ch, input bit wr, input logic [7:0] a, input logic [7:0] d);
    t_wr[ch] = wr; t_addr[ch] = a; t_wd[ch] = d;
    req_write[ch] = wr;
    req_addr[ch*8 +: 8] = a;
    req_wdata[ch*8 +: 8] = d;
  endtask

  // Bytes the PHY should accept: TX_CMD, optional extended address, optional data.
  task automatic build_exp(input bit wr, input logic [7:0] a, input logic [7:0] d);
    exp_q.delete();
    if (a > 8'd63) begin
      exp_q.push_back(wr ? 8'hAF : 8'hEF);
      exp_q.push_back(a);
    end else begin
      exp_q.push_back((wr ? 8'h80 : 8'hC0) | a);
    end
    if (wr) exp_q.push_back(d);
  endtask

  // PHY responder for one transaction of channel ch; returns at the ack.
  task automatic serve(input int ch, input int abort_at, input bit no_nxt, input logic [7:0] rd_ret);
    int acc = 0, phase = 0, hold = 0, n_tx;
    bit aborted = 0;
    bit wr = t_wr[ch];
    build_exp(t_wr[ch], t_addr[ch], t_wd[ch]);
    n_tx = exp_q.size();
    got_q.delete(); got_ack = '0; got_err = 0; got_rdata = 0;
    got_stp = 0; got_stp_bad = 0; got_busy = 0; got_done = 0;
    for (int cyc = 0; cyc < 600 && !got_done; cyc++) begin
      @(negedge phy_clk);
      phy_nxt = 1'b0;
      if (req_ack != '0) begin
        got_done = 1; got_ack = req_ack; got_err = rsp_err; got_rdata = rsp_rdata;
        phy_dir = 1'b0;
      end else begin
        if (phy_stp) begin got_stp++; if (phy_d_out !== 8'h00) got_stp_bad++; end
        if (bus_busy) got_busy++;
        if (phase == 0 && bus_busy && !phy_stp) begin
          if (acc < n_tx) begin
            if (acc == abort_at && !aborted) begin
              phy_dir = 1'b1; phy_d_in = 8'h2A; aborted = 1; hold = 1; phase = 3;
            end else if (!no_nxt && $urandom_range(0, 2) != 0) begin
              phy_nxt = 1'b1; got_q.push_back(phy_d_out); acc++;
            end
          end else if (!wr) begin
            phy_dir = 1'b1; phase = 1;
          end
        end else if (phase == 1) begin
          phy_d_in = rd_ret; phase = 2;
        end else if (phase == 3) begin
          if (hold > 0) hold--;
          else begin phy_dir = 1'b0; phase = 0; acc = 0; got_q.delete(); end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1; bus_free = 1; phy_dir = 0; phy_nxt = 0; phy_d_in = 0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge phy_clk);
    checks++;
    if ({bus_busy, phy_d_oe, phy_stp, rsp_err, rx_cmd_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 00000", {bus_busy, phy_d_oe, phy_stp, rsp_err, rx_cmd_valid});
    end
    checks++;
    if ({phy_d_out, rsp_rdata, rx_cmd, req_ack} !== '0) begin
      errors++; $display("FAIL reset_data: d_out=%h rdata=%h rx_cmd=%h ack=%b required all 0", phy_d_out, rsp_rdata, rx_cmd, req_ack);
    end
    reset = 0; rr_ptr = 0;
    @(negedge phy_clk);
    checks++;
    if (phy_d_oe !== 1'b1) begin errors++; $display("FAIL d_oe_idle: got %b required 1", phy_d_oe); end
  endtask

  task automatic test_immediate_write();
    set_req(0, 1'b1, 8'h04, 8'h45);
    req_valid = 3'b001;
    serve(0, -1, 1'b0, 8'h00);
    req_valid = '0;
    $display("txn imm_write ch=0 addr=04 ack=%b err=%0d stp=%0d", got_ack, got_err, got_stp);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'h84 || got_q[1] !== 8'h45) begin
      errors++; $display("FAIL imm_write_bytes: got %p required 84 45", got_q);
    end
    checks++;
    if (got_ack !== 3'b001 || got_err !== 1'b0) begin
      errors++; $display("FAIL imm_write_ack: ack=%b err=%b required 001/0", got_ack, got_err);
    end
    checks++;
    if (got_stp != 1 || got_stp_bad != 0) begin
      errors++; $display("FAIL imm_write_stp: stp=%0d bad=%0d required 1/0", got_stp, got_stp_bad);
    end
    rr_ptr = 1;
  endtask

  task automatic test_extended_read();
    set_req(1, 1'b0, 8'h81, 8'h00);
    req_valid = 3'b010;
    serve(1, -1, 1'b0, 8'h5A);
    req_valid = '0;
    $display("txn ext_read ch=1 addr=81 ack=%b rdata=%h err=%0d", got_ack, got_rdata, got_err);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'hEF || got_q[1] !== 8'h81) begin
      errors++; $display("FAIL ext_read_bytes: got %p required ef 81", got_q);
    end
    checks++;
    if (got_ack !== 3'b010 || got_err !== 1'b0 || got_rdata !== 8'h5A) begin
      errors++; $display("FAIL ext_read_rsp: ack=%b err=%b rdata=%h required 010/0/5a", got_ack, got_err, got_rdata);
    end
    checks++;
    if (got_stp != 0) begin errors++; $display("FAIL ext_read_stp: got %0d required 0", got_stp); end
    rr_ptr = 2;
  endtask

  task automatic test_rx_cmd(input logic [7:0] val);
    req_valid = '0;
    @(negedge phy_clk); phy_dir = 1'b1; phy_nxt = 1'b0; phy_d_in = 8'hFF;
    @(negedge phy_clk); phy_d_in = val;
    checks++;
    if (rx_cmd_valid !== 1'b0) begin errors++; $display("FAIL rx_early: valid=%b required 0", rx_cmd_valid); end
    @(negedge phy_clk);
    $display("txn rx_cmd val=%h rx_cmd=%h valid=%b", val, rx_cmd, rx_cmd_valid);
    checks++;
    if (rx_cmd !== val || rx_cmd_valid !== 1'b1 || phy_d_oe !== 1'b0 || req_ack !== '0) begin
      errors++; $display("FAIL rx_capture: rx_cmd=%h valid=%b oe=%b ack=%b required %h/1/0/000", rx_cmd, rx_cmd_valid, phy_d_oe, req_ack, val);
    end
    @(negedge phy_clk);
    checks++;
    if (rx_cmd_valid !== 1'b0 || bus_busy !== 1'b0) begin
      errors++; $display("FAIL rx_pulse: valid=%b busy=%b required 0/0", rx_cmd_valid, bus_busy);
    end
    phy_dir = 1'b0;
    @(negedge phy_clk);
  endtask

  task automatic test_timeout();
    set_req(0, 1'b0, 8'($urandom_range(0, 255)), 8'h00);
    req_valid = 3'b001;
    serve(0, -1, 1'b1, 8'h00);
    req_valid = '0;
    $display("txn timeout ch=0 ack=%b err=%0d busy_cycles=%0d", got_ack, got_err, got_busy);
    checks++;
    if (got_ack !== 3'b001 || got_err !== 1'b1) begin
      errors++; $display("FAIL timeout_ack: ack=%b err=%b required 001/1", got_ack, got_err);
    end
    checks++;
    if (got_busy != 64 || got_stp != 0) begin
      errors++; $display("FAIL timeout_len: cmd_cycles=%0d stp=%0d required 64/0", got_busy, got_stp);
    end
    rr_ptr = 1;
  endtask

  task automatic test_abort();
    set_req(2, 1'b1, 8'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
    req_valid = 3'b100;
    serve(2, 1, 1'b0, 8'h00);
    req_valid = '0;
    $display("txn abort ch=2 ack=%b err=%0d stp=%0d", got_ack, got_err, got_stp);
`ifdef ULPI_REG_RETRY_EN
    checks++;
    if (got_ack !== 3'b100 || got_err !== 1'b0 || got_stp != 1) begin
      errors++; $display("FAIL abort_retry: ack=%b err=%b stp=%0d required 100/0/1", got_ack, got_err, got_stp);
    end
    checks++;
    if (!bytes_match()) begin errors++; $display("FAIL abort_retry_bytes: got %p required %p", got_q, exp_q); end
`else
    checks++;
    if (got_ack !== 3'b100 || got_err !== 1'b1 || got_stp != 0) begin
      errors++; $display("FAIL abort_err: ack=%b err=%b stp=%0d required 100/1/0", got_ack, got_err, got_stp);
    end
`endif
    rr_ptr = 0;
  endtask

  task automatic test_bus_free();
    int seen_busy = 0;
    bus_free = 1'b0;
    set_req(2, 1'b1, 8'h0A, 8'($urandom_range(0, 255)));
    req_valid = 3'b100;
    repeat (8) begin @(negedge phy_clk); if (bus_busy) seen_busy++; end
    checks++;
    if (seen_busy != 0) begin errors++; $display("FAIL bus_free_gate: busy cycles=%0d required 0", seen_busy); end
    bus_free = 1'b1;
    serve(2, -1, 1'b0, 8'h00);
    req_valid = '0;
    $display("txn bus_free ch=2 ack=%b err=%0d", got_ack, got_err);
    checks++;
    if (got_ack !== 3'b100 || got_err !== 1'b0 || !bytes_match()) begin
      errors++; $display("FAIL bus_free_txn: ack=%b err=%b bytes=%p required 100/0/%p", got_ack, got_err, got_q, exp_q);
    end
    rr_ptr = 0;
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic [NR-1:0] mask = NR'($urandom_range(1, 7));
      logic [7:0] rd = 8'($urandom_range(0, 255));
      int exp_ch;
      for (int c = 0; c < NR; c++)
        set_req(c, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 63)) : 8'($urandom_range(64, 255)),
                8'($urandom_range(0, 255)));
      exp_ch = pick(mask, rr_ptr);
      req_valid = mask;
      serve(exp_ch, -1, 1'b0, rd);
      req_valid = '0;
      $display("txn rand mask=%b ch=%0d wr=%0d addr=%h ack=%b err=%0d rdata=%h", mask, exp_ch, t_wr[exp_ch], t_addr[exp_ch], got_ack, got_err, got_rdata);
      checks++;
      if (got_ack !== NR'(1 << exp_ch) || got_err !== 1'b0) begin
        errors++; $display("FAIL rand_ack[%0d]: ack=%b err=%b required %b/0", i, got_ack, got_err, NR'(1 << exp_ch));
      end
      checks++;
      if (!bytes_match()) begin errors++; $display("FAIL rand_bytes[%0d]: got %p required %p", i, got_q, exp_q); end
      checks++;
      if (t_wr[exp_ch] ? (got_stp != 1) : (got_rdata !== rd || got_stp != 0)) begin
        errors++; $display("FAIL rand_tail[%0d]: stp=%0d rdata=%h required stp=%0d rdata=%h", i, got_stp, got_rdata, t_wr[exp_ch], rd);
      end
      rr_ptr = (exp_ch + 1) % NR;
    end
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    set_req(1, 1'b1, 8'h0A, 8'($urandom_range(0, 255)));
    req_valid = 3'b010;
    while (!bus_busy && waited < 10) begin @(negedge phy_clk); waited++; end
    checks++;
    if (!bus_busy) begin errors++; $display("FAIL mid_start: busy=%b required 1", bus_busy); end
    reset = 1'b1;
    @(negedge phy_clk);
    reset = 1'b0; req_valid = '0;
    checks++;
    if (bus_busy !== 1'b0 || phy_stp !== 1'b0 || req_ack !== '0) begin
      errors++; $display("FAIL mid_reset: busy=%b stp=%b ack=%b required 0/0/000", bus_busy, phy_stp, req_ack);
    end
    @(negedge phy_clk);
    checks++;
    if (req_ack !== '0 || bus_busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_after: ack=%b busy=%b required 000/0", req_ack, bus_busy);
    end
    rr_ptr = 0;
  endtask

  task automatic test_round_robin(input int n);
    int order[$];
    for (int c = 0; c < NR; c++)
      set_req(c, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    req_valid = '1;
    for (int i = 0; i < n; i++) begin
      int exp_ch = pick(3'b111, rr_ptr);
      serve(exp_ch, -1, 1'b0, 8'($urandom_range(0, 255)));
      $display("txn rr step=%0d ch=%0d ack=%b err=%0d", i, exp_ch, got_ack, got_err);
      checks++;
      if (got_ack !== NR'(1 << exp_ch) || got_err !== 1'b0 || !bytes_match()) begin
        errors++; $display("FAIL rr_step[%0d]: ack=%b err=%b required %b/0", i, got_ack, got_err, NR'(1 << exp_ch));
      end
      order.push_back(exp_ch);
      rr_ptr = (exp_ch + 1) % NR;
      set_req(exp_ch, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    req_valid = '0;
    checks++;
    if (got_ack !== NR'(1 << order[n-1]) || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 0) begin
      errors++; $display("FAIL rr_order: got %p last_ack=%b required 0 1 2 0 ...", order, got_ack);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_immediate_write();
    test_extended_read();
    test_rx_cmd(8'h4E);
    test_rx_cmd(8'($urandom_range(0, 255)));
    test_timeout();
    test_abort();
    test_bus_free();
    test_random(16);
    test_reset_mid();
    test_round_robin(6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb2_ulpi_regctl.md
Name: usb2_ulpi_regctl

Overview:
- Parametrised ULPI register-access engine, successor to the single-requester immediate-only register path in the ULPI link.
- Arbitrates NUM_REQ requesters (chirp FSM, OTG control, debug) round-robin onto the ULPI bus.
- Supports immediate (6-bit) and extended (8-bit) addresses, reads and writes, PHY-abort detection and a NXT timeout.
- Captures RX_CMD bytes seen during idle turnarounds; sits beside the packet path, gated by the link's bus_free.

Parameters:
- NUM_REQ, 3, number of requester channels (1..8).
- TIMEOUT_CYC, 64, max cycles waiting for NXT/DIR per phase before error.
- RETRY_MAX, 3, max retries after PHY abort (ULPI_REG_RETRY_EN only).

Ports:
- phy_clk  in  1  60 MHz ULPI clock.
- reset  in  1  synchronous, active-high.
- bus_free  in  1  link grants ULPI bus (no packet TX/RX in progress).
- bus_busy  out  1  engine owns the bus (state != IDLE).
- phy_d_in  in  8  ULPI data from PHY.
- phy_d_out  out  8  ULPI data to PHY.
- phy_d_oe  out  1  data output enable.
- phy_dir  in  1  ULPI DIR.
- phy_nxt  in  1  ULPI NXT.
- phy_stp  out  1  ULPI STP.
- req_valid  in  NUM_REQ  per-channel request, held until ack.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  8*NUM_REQ  register address; >0x3F selects extended.
- req_wdata  in  8*NUM_REQ  write data.
- req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot.
- rsp_rdata  out  8  read data, valid with req_ack.
- rsp_err  out  1  timeout/abort failure, valid with req_ack.
- rx_cmd  out  8  last RX_CMD captured.
- rx_cmd_valid  out  1  one-cycle pulse on capture.

Behaviour:
- Reset values: all outputs 0; rx_cmd 0; arbiter pointer 0; state IDLE.
- phy_d_oe = !phy_dir registered one cycle (turnaround); phy_d_out is 0 whenever not in CMD/EXT/WDATA.
- States: IDLE, CMD, EXT, WDATA, STP, TURN, RDATA, ABORT, DONE.
- IDLE: with bus_free & |req_valid & !phy_dir, latch the winner's fields (round-robin, pointer advances to winner+1 mod NUM_REQ) -> CMD.
  - DIR rising edge with !phy_nxt -> capture phy_d_in next cycle into rx_cmd and pulse rx_cmd_valid.
- CMD: drive {2'b10 write / 2'b11 read, addr[5:0]}, or 6'h2F when extended.
  - On NXT: -> EXT if extended; else -> WDATA (write) or TURN (read).
- EXT: drive addr[7:0]; on NXT -> WDATA or TURN.
- WDATA: drive wdata; on NXT -> STP.
- STP: phy_stp = 1 for one cycle, phy_d_out = 0 -> DONE.
- TURN: wait phy_dir high with !phy_nxt -> RDATA.
  - DIR high with NXT high is a receive packet -> ABORT.
- RDATA: latch phy_d_in into rsp_rdata -> DONE.
- DONE: pulse req_ack[winner], rsp_err 0 -> IDLE.
- ABORT: entered when phy_dir rises in CMD/EXT/WDATA, or on the TURN case above.
  - Release bus; wait phy_dir low; then retry or fail (see Optional Feature).
- Timeout: per-phase counter, cleared on every state change.
  - Reaching TIMEOUT_CYC -> ack with rsp_err = 1, no STP, -> IDLE.
- bus_free deasserting mid-transaction is ignored; the transaction completes.
- Requester dropping req_valid before ack: transaction still completes, ack still pulsed.
- reset mid-transaction: immediate return to IDLE, no STP, no ack.

Optional Feature:
- ULPI_REG_RETRY_EN defined: after ABORT, re-issue from CMD with the same latched fields, up to RETRY_MAX times.
  - Retry count exhausted -> ack with rsp_err = 1.
- Not defined: ABORT -> ack with rsp_err = 1 immediately. RETRY_MAX unused.

Decomposition:
- Package usb2_ulpi_pkg: TX_CMD prefixes (REGWR 2'b10, REGRD 2'b11), EXT_ADDR 6'h2F, state encodings, register addresses 0x04 (Function Control) and 0x0A (OTG Control).
- Sub-module usb2_ulpi_rr_arb: parametrised round-robin arbiter (NUM_REQ requests in, one-hot grant out, pointer update on accept).

Test Plan:
- Immediate write: ch0 writes 0x45 to 0x04, PHY gives NXT on cycles 2 and 3 -> bus shows 0x84, then 0x45, then STP with 0x00; req_ack[0] one pulse, rsp_err 0.
- Extended read: ch1 reads 0x81 -> bus shows 0xEF, then 0x81; DIR high, PHY returns 0x5A -> rsp_rdata 0x5A with req_ack[1].
- Round-robin fairness: all three channels request continuously -> acks in order 0,1,2,0; no channel starved.
- PHY abort: DIR rises during WDATA.
  - RETRY_EN: retried once, ack with err 0.
  - Without RETRY_EN: ack with rsp_err 1.
- Timeout: NXT never asserted -> ack with rsp_err 1 after 64 cycles in CMD; phy_stp stays 0.
- RX_CMD capture: in IDLE, DIR rises with NXT low and data 0x4E -> rx_cmd 0x4E, rx_cmd_valid one pulse, no req_ack.
